// File: rtl/roi_pingpong_buffer.sv
// Double-banked ROI store: writes the current frame's extended ROI into one bank while
// streaming the previous frame's ROI, shifted by the point motion (dx, dy), out of the other.
module roi_pingpong_buffer #(
  parameter int NEIGH_SIZE   = 10,
  parameter int BORDER_WIDTH = 2,
  parameter int PIXEL_WIDTH  = 11,
  parameter int OUT_WIDTH    = 8,
  parameter int X_WIDTH      = 12,
  parameter int Y_WIDTH      = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] center_pixel,
  input  logic                   in_extended_roi,
  input  logic                   roi_end,
  input  logic                   center_vsync,
  input  logic [X_WIDTH-1:0]     point_x0,
  input  logic [Y_WIDTH-1:0]     point_y0,
  output logic [OUT_WIDTH-1:0]   prev_frame_pixel,
  output logic                   prev_valid,
  output logic                   prev_oob,
  output logic                   prev_ready,
  output logic                   overflow
);

  localparam int WIN   = 2 * (NEIGH_SIZE + BORDER_WIDTH) + 1;
  localparam int DEPTH = WIN * WIN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(WIN);
  localparam int CNT_W = AW + 1;
  localparam int DXW   = X_WIDTH + 1;
  localparam int DYW   = Y_WIDTH + 1;
  localparam int SW    = ((DXW > DYW) ? DXW : DYW) + 1;

  // Frame control
  logic                   vsync_q, fs_q, fs_dly_q;
  logic                   bank_sel_q;
  logic [1:0]             complete_q;
  logic                   prev_ready_q, overflow_q;
  logic [X_WIDTH-1:0]     ref_x_q;
  logic [Y_WIDTH-1:0]     ref_y_q;
  logic signed [DXW-1:0]  dx_q;
  logic signed [DYW-1:0]  dy_q;

  // Write side
  logic [AW-1:0]          wr_addr_q;
  logic [CW-1:0]          row_q, col_q;
  logic [CNT_W-1:0]       wr_cnt_q;

  // Read pipeline
  logic                   s1_valid_q, s1_oob_q, s1_bank_q;
  logic [AW-1:0]          s1_addr_q;
  logic                   s2_valid_q, s2_oob_q;
  logic [OUT_WIDTH-1:0]   ram_q;
  logic [OUT_WIDTH-1:0]   prev_pixel_q;
  logic                   prev_valid_q, prev_oob_q;

  logic [PIXEL_WIDTH-1:0] mem0 [DEPTH];
  logic [PIXEL_WIDTH-1:0] mem1 [DEPTH];

  logic signed [SW-1:0]   rd_row, rd_col;
  logic                   in_win;
  logic [AW-1:0]          rd_addr_d;
  logic                   out_hit;

  // Aligned read coordinate in the previous frame's window.
  assign rd_row    = SW'($signed({1'b0, row_q})) + SW'(dy_q);
  assign rd_col    = SW'($signed({1'b0, col_q})) + SW'(dx_q);
  assign in_win    = !rd_row[SW-1] && (rd_row < SW'(WIN)) &&
                     !rd_col[SW-1] && (rd_col < SW'(WIN));
  assign rd_addr_d = AW'(rd_row[CW-1:0]) * AW'(WIN) + AW'(rd_col[CW-1:0]);
  assign out_hit   = s2_valid_q && prev_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      fs_q         <= 1'b0;
      fs_dly_q     <= 1'b0;
      bank_sel_q   <= 1'b0;
      complete_q   <= '0;
      prev_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      ref_x_q      <= '0;
      ref_y_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      wr_addr_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wr_cnt_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_oob_q     <= 1'b0;
      s1_bank_q    <= 1'b0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_oob_q     <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_oob_q   <= 1'b0;
      prev_pixel_q <= '0;
    end else begin
      vsync_q  <= center_vsync;
      fs_q     <= center_vsync & ~vsync_q;
      fs_dly_q <= fs_q;

      if (roi_end) begin
        ref_x_q                <= point_x0;
        ref_y_q                <= point_y0;
        complete_q[bank_sel_q] <= 1'b1;
      end

      // roi_end in the same cycle as fs still counts toward the bank being retired.
      if (fs_q) begin
        bank_sel_q              <= ~bank_sel_q;
        complete_q[~bank_sel_q] <= 1'b0;
        prev_ready_q            <= complete_q[bank_sel_q] | roi_end;
        wr_addr_q               <= '0;
        row_q                   <= '0;
        col_q                   <= '0;
        wr_cnt_q                <= '0;
      end else if (in_extended_roi) begin
        wr_addr_q <= (wr_addr_q == AW'(DEPTH - 1)) ? '0 : wr_addr_q + 1'b1;
        if (col_q == CW'(WIN - 1)) begin
          col_q <= '0;
          row_q <= (row_q == CW'(WIN - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (wr_cnt_q == CNT_W'(DEPTH)) overflow_q <= 1'b1;
        else                           wr_cnt_q   <= wr_cnt_q + 1'b1;
      end

      if (fs_dly_q) begin
        dx_q <= $signed({1'b0, point_x0}) - $signed({1'b0, ref_x_q});
        dy_q <= $signed({1'b0, point_y0}) - $signed({1'b0, ref_y_q});
      end

      s1_valid_q   <= in_extended_roi;
      s1_oob_q     <= ~in_win;
      s1_bank_q    <= ~bank_sel_q;
      s1_addr_q    <= in_win ? rd_addr_d : '0;
      s2_valid_q   <= s1_valid_q;
      s2_oob_q     <= s1_oob_q;
      prev_valid_q <= out_hit;
      prev_oob_q   <= out_hit & s2_oob_q;
      prev_pixel_q <= (out_hit && !s2_oob_q) ? ram_q : '0;
    end
  end

  // NOTE: the banks carry no reset; whether a bank's contents mean anything is decided by
  // complete_q, so clearing DEPTH words would only cost a reset fan-out and block RAM inference.
  always_ff @(posedge clk) begin
    if (in_extended_roi) begin
      if (bank_sel_q) mem1[wr_addr_q] <= center_pixel;
      else            mem0[wr_addr_q] <= center_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q <= '0;
    end else if (s1_valid_q && !s1_oob_q) begin
      ram_q <= s1_bank_q ? mem1[s1_addr_q][PIXEL_WIDTH-1 -: OUT_WIDTH]
                         : mem0[s1_addr_q][PIXEL_WIDTH-1 -: OUT_WIDTH];
    end
  end

  assign prev_frame_pixel = prev_pixel_q;
  assign prev_valid       = prev_valid_q;
  assign prev_oob         = prev_oob_q;
  assign prev_ready       = prev_ready_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_roi_pingpong_buffer.sv
// Bench for roi_pingpong_buffer: frame-level reference model (two images, a motion offset and a
// short output queue) compared against the DUT every cycle, plus hand-derived frame totals.
module tb_roi_pingpong_buffer;

  localparam int WIN   = 25;
  localparam int DEPTH = WIN * WIN;
  localparam int PW    = 11;
  localparam int OW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] center_pixel;
  logic          in_extended_roi;
  logic          roi_end;
  logic          center_vsync;
  logic [11:0]   point_x0;
  logic [10:0]   point_y0;
  logic [OW-1:0] prev_frame_pixel;
  logic          prev_valid;
  logic          prev_oob;
  logic          prev_ready;
  logic          overflow;

  always #5 clk = ~clk;

  roi_pingpong_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .center_pixel     (center_pixel),
    .in_extended_roi  (in_extended_roi),
    .roi_end          (roi_end),
    .center_vsync     (center_vsync),
    .point_x0         (point_x0),
    .point_y0         (point_y0),
    .prev_frame_pixel (prev_frame_pixel),
    .prev_valid       (prev_valid),
    .prev_oob         (prev_oob),
    .prev_ready       (prev_ready),
    .overflow         (overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model, advanced once per rising edge with the inputs the DUT just sampled.
  typedef struct packed {
    logic          v;
    logic          o;
    logic [OW-1:0] p;
  } out_t;

  out_t          pend[$];
  out_t          e_out;
  bit            e_ready, e_ovf;
  logic [PW-1:0] img_cur  [DEPTH];
  logic [PW-1:0] img_prev [DEPTH];
  int            m_waddr, m_wcnt, m_dx, m_dy, m_refx, m_refy;
  bit            m_ready, m_ovf, m_done, m_vs_prev, m_fs_pend;

  task automatic model_edge();
    out_t          nw;
    int            r, c;
    logic [PW-1:0] tmp [DEPTH];
    if (rst) begin
      pend.delete();
      m_ready = 0; m_ovf = 0; m_done = 0; m_vs_prev = 0; m_fs_pend = 0;
      m_waddr = 0; m_wcnt = 0; m_dx = 0; m_dy = 0; m_refx = 0; m_refy = 0;
      e_out = '0;
    end else begin
      if (roi_end) begin
        m_done = 1;
        m_refx = int'(point_x0);
        m_refy = int'(point_y0);
      end
      if (m_fs_pend) begin
        m_ready  = m_done;
        m_done   = 0;
        tmp      = img_prev;
        img_prev = img_cur;
        img_cur  = tmp;
        m_waddr  = 0;
        m_wcnt   = 0;
        m_dx     = int'(point_x0) - m_refx;
        m_dy     = int'(point_y0) - m_refy;
      end
      m_fs_pend = center_vsync && !m_vs_prev;
      m_vs_prev = center_vsync;
      nw = '0;
      if (in_extended_roi) begin
        r = m_waddr / WIN + m_dy;
        c = m_waddr % WIN + m_dx;
        if (m_ready) begin
          nw.v = 1'b1;
          if (r < 0 || r >= WIN || c < 0 || c >= WIN) nw.o = 1'b1;
          else nw.p = img_prev[r * WIN + c][PW-1 -: OW];
        end
        img_cur[m_waddr] = center_pixel;
        if (m_wcnt == DEPTH) m_ovf = 1;
        else                 m_wcnt++;
        m_waddr = (m_waddr + 1) % DEPTH;
      end
      pend.push_back(nw);
      if (pend.size() > 2) e_out = pend.pop_front();
      else                 e_out = '0;
    end
    e_ready = m_ready;
    e_ovf   = m_ovf;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Single compare process, half a cycle away from the active edge.
  bit chk_en  = 0;
  int n_valid = 0;
  int n_oob   = 0;
  int pix_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("prev_valid",       prev_valid,       e_out.v);
      check("prev_oob",         prev_oob,         e_out.o);
      check("prev_frame_pixel", prev_frame_pixel, e_out.p);
      check("prev_ready",       prev_ready,       e_ready);
      check("overflow",         overflow,         e_ovf);
      if (prev_valid === 1'b1) begin
        n_valid++;
        pix_log.push_back(int'(prev_frame_pixel));
        if (prev_oob === 1'b1) n_oob++;
      end
    end
  end

  task automatic run_frame(input int n_wr, input int px, input int py, input bit ramp,
                           input bit finish, output bit rdy, output int nv, output int no,
                           output int first_pix);
    int v0, o0, l0, wr;
    point_x0     = 12'(px);
    point_y0     = 11'(py);
    center_vsync = 1'b1;
    tick();
    repeat (4) tick();
    rdy = prev_ready;
    v0  = n_valid;
    o0  = n_oob;
    l0  = pix_log.size();
    wr  = 0;
    while (wr < n_wr) begin
      if ($urandom_range(3) != 0) begin
        in_extended_roi = 1'b1;
        center_pixel    = ramp ? PW'(wr << 3) : PW'($urandom);
        wr++;
      end else begin
        in_extended_roi = 1'b0;
        center_pixel    = PW'($urandom);
      end
      tick();
    end
    in_extended_roi = 1'b0;
    if (finish) begin
      repeat (4) tick();
      roi_end = 1'b1;
      tick();
      roi_end      = 1'b0;
      center_vsync = 1'b0;
      repeat (2) tick();
    end
    nv        = n_valid - v0;
    no        = n_oob - o0;
    first_pix = (pix_log.size() > l0) ? pix_log[l0] : -1;
  endtask

  initial begin
    bit rdy;
    int nv, no, fp, px, py;
    rst             = 1'b1;
    center_pixel    = '0;
    in_extended_roi = 1'b0;
    roi_end         = 1'b0;
    center_vsync    = 1'b0;
    point_x0        = '0;
    point_y0        = '0;
    tick();
    chk_en = 1;
    repeat (2) tick();
    check("reset_valid", prev_valid, 0);
    check("reset_ready", prev_ready, 0);
    check("reset_ovf",   overflow,   0);
    check("reset_pixel", prev_frame_pixel, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Frame 1: nothing stored yet.
    run_frame(DEPTH, 100, 50, 1'b1, 1'b1, rdy, nv, no, fp);
    check("f1_ready_at_start", rdy, 0);
    check("f1_valid_count",    nv, 0);
    check("f1_ready_after_end", prev_ready, 0);

    // Frame 2: static point, outputs replay frame 1 one-for-one.
    run_frame(DEPTH, 100, 50, 1'b1, 1'b1, rdy, nv, no, fp);
    check("f2_ready",       rdy, 1);
    check("f2_valid_count", nv, DEPTH);
    check("f2_oob_count",   no, 0);
    check("f2_first_pixel", fp, 0);

    // Frame 3: moved (+1,+2); first read lands on index 51, col 24 / rows 23-24 are out.
    run_frame(DEPTH, 101, 52, 1'b0, 1'b1, rdy, nv, no, fp);
    check("f3_valid_count", nv, DEPTH);
    check("f3_first_pixel", fp, 51);
    check("f3_oob_count",   no, 73);

    // Frame 4: motion (-30,0) leaves every read outside the window.
    run_frame(DEPTH, 71, 52, 1'b0, 1'b1, rdy, nv, no, fp);
    check("f4_oob_count", no, DEPTH);

    // Frame 5: 630 writes trip the sticky overflow.
    run_frame(DEPTH + 5, 71, 52, 1'b0, 1'b1, rdy, nv, no, fp);
    check("f5_overflow",    overflow, 1);
    check("f5_valid_count", nv, DEPTH + 5);

    // Frame 6: small random motion; overflow survives the frame start.
    px = 71 + int'($urandom_range(12)) - 6;
    py = 52 + int'($urandom_range(12)) - 6;
    run_frame(DEPTH, px, py, 1'b0, 1'b1, rdy, nv, no, fp);
    check("f6_overflow_kept", overflow, 1);
    check("f6_valid_count",   nv, DEPTH);

    // Frame 7: reset after write 300.
    run_frame(300, px + 3, py - 2, 1'b0, 1'b0, rdy, nv, no, fp);
    rst          = 1'b1;
    center_vsync = 1'b0;
    tick();
    check("rst_mid_valid", prev_valid, 0);
    check("rst_mid_oob",   prev_oob,   0);
    check("rst_mid_pixel", prev_frame_pixel, 0);
    check("rst_mid_ready", prev_ready, 0);
    check("rst_mid_ovf",   overflow,   0);
    rst = 1'b0;
    repeat (3) tick();

    // Frame 8 behaves as a first frame; frame 9 reads it back with random motion.
    run_frame(DEPTH, 200, 300, 1'b0, 1'b1, rdy, nv, no, fp);
    check("f8_ready", rdy, 0);
    check("f8_valid_count", nv, 0);
    px = 200 + int'($urandom_range(16)) - 8;
    py = 300 + int'($urandom_range(16)) - 8;
    run_frame(DEPTH, px, py, 1'b0, 1'b1, rdy, nv, no, fp);
    check("f9_ready", rdy, 1);
    check("f9_valid_count", nv, DEPTH);

    repeat (4) tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
